// File: rtl/trapez_shaper_ctrl_if.sv
// Control/result bundle between the trapezoidal shaper controller and its surroundings.
// slave = controller side, master = driver/consumer side.
interface trapez_shaper_ctrl_if #(
  parameter int CONST_W = 10,
  parameter int DATA_W  = 16,
  parameter int DROP_W  = 16
);
  logic               trapez_ena;
  logic               trigger;
  logic               cfg_wr;
  logic [CONST_W-1:0] cfg_k;
  logic [CONST_W-1:0] cfg_l;
  logic [CONST_W-1:0] cfg_m1;
  logic [CONST_W-1:0] cfg_m2;
  logic [DATA_W-1:0]  shaper_data;
  logic               pulse_time;
  logic [CONST_W-1:0] k_trapez;
  logic [CONST_W-1:0] l_trapez;
  logic [CONST_W-1:0] M1_trapez;
  logic [CONST_W-1:0] M2_trapez;
  logic [DATA_W-1:0]  energy_data;
  logic               energy_pileup;
  logic               energy_valid;
  logic               energy_ready;
  logic               end_impuls;
  logic               busy;
  logic               cfg_err;
  logic [DROP_W-1:0]  drop_cnt;

  modport slave (
    input  trapez_ena, trigger, cfg_wr, cfg_k, cfg_l, cfg_m1, cfg_m2, shaper_data, energy_ready,
    output pulse_time, k_trapez, l_trapez, M1_trapez, M2_trapez, energy_data, energy_pileup,
           energy_valid, end_impuls, busy, cfg_err, drop_cnt
  );

  modport master (
    output trapez_ena, trigger, cfg_wr, cfg_k, cfg_l, cfg_m1, cfg_m2, shaper_data, energy_ready,
    input  pulse_time, k_trapez, l_trapez, M1_trapez, M2_trapez, energy_data, energy_pileup,
           energy_valid, end_impuls, busy, cfg_err, drop_cnt
  );
endinterface

// File: rtl/trapez_shaper_ctrl.sv
// Trapezoidal shaper pulse sequencer: times rise/flat/fall per trigger, captures flat-top peak,
// reports it over valid/ready (REPORT holds until accepted); shadows shaper constants.
module trapez_shaper_ctrl #(
  parameter int CONST_W   = 10,
  parameter int DATA_W    = 16,
  parameter int PIPE_LAT  = 8,
  parameter int SHIFT_LEN = 60,
  parameter int DROP_W    = 16
) (
  input logic                  clk,
  input logic                  reset,
  trapez_shaper_ctrl_if.slave  bus
);
  localparam int CW = CONST_W + 1;
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] MAX_SUM = CW'(SHIFT_LEN - 1);
  localparam logic [CW-1:0] PIPE    = CW'(PIPE_LAT);

  typedef enum logic [2:0] {IDLE, RISE, FLAT, FALL, REPORT} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [CONST_W-1:0] r_k, r_l, r_m1, r_m2;
  logic [CONST_W-1:0] r_pk, r_pl, r_pm1, r_pm2;
  logic               r_pend_vld;
  logic [DATA_W-1:0]  r_peak;
  logic               r_pileup;
  logic               r_pulse_time;
  logic               r_end_impuls;
  logic               r_busy;
  logic               r_cfg_err;
  logic               r_energy_valid;
  logic               r_energy_pileup;
  logic [DATA_W-1:0]  r_energy_data;
  logic [DROP_W-1:0]  r_drop_cnt;

  logic               w_cfg_ok, w_cfg_new, w_active, w_to_idle, w_drop;
  logic [CONST_W-1:0] w_k_eff;

  assign w_cfg_ok  = (bus.cfg_k != '0) && (({1'b0, bus.cfg_k} + {1'b0, bus.cfg_l}) <= MAX_SUM);
  assign w_cfg_new = bus.cfg_wr && w_cfg_ok;
  // A same-cycle write in IDLE must time the pulse it starts.
  assign w_k_eff   = w_cfg_new ? bus.cfg_k : r_k;
  assign w_active  = (r_state == RISE) || (r_state == FLAT) || (r_state == FALL);
  assign w_to_idle = (w_active && !bus.trapez_ena) || ((r_state == REPORT) && bus.energy_ready);
  assign w_drop    = bus.trigger && (!bus.trapez_ena || (r_state == REPORT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_k        <= CONST_W'(4);
      r_l        <= CONST_W'(2);
      r_m1       <= '0;
      r_m2       <= '0;
      r_pk       <= '0;
      r_pl       <= '0;
      r_pm1      <= '0;
      r_pm2      <= '0;
      r_pend_vld <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_cfg_err <= bus.cfg_wr && !w_cfg_ok;
      if ((r_state == IDLE) || w_to_idle) begin
        if (w_cfg_new) begin
          r_k  <= bus.cfg_k;
          r_l  <= bus.cfg_l;
          r_m1 <= bus.cfg_m1;
          r_m2 <= bus.cfg_m2;
        end else if (r_pend_vld) begin
          r_k  <= r_pk;
          r_l  <= r_pl;
          r_m1 <= r_pm1;
          r_m2 <= r_pm2;
        end
        r_pend_vld <= 1'b0;
      end else if (w_cfg_new) begin
        r_pk       <= bus.cfg_k;
        r_pl       <= bus.cfg_l;
        r_pm1      <= bus.cfg_m1;
        r_pm2      <= bus.cfg_m2;
        r_pend_vld <= 1'b1;
      end
      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_peak          <= '0;
      r_pileup        <= 1'b0;
      r_pulse_time    <= 1'b0;
      r_end_impuls    <= 1'b0;
      r_busy          <= 1'b0;
      r_energy_valid  <= 1'b0;
      r_energy_pileup <= 1'b0;
      r_energy_data   <= '0;
    end else begin
      r_end_impuls <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.trapez_ena && bus.trigger) begin
            r_state      <= RISE;
            r_cnt        <= {1'b0, w_k_eff} + PIPE;
            r_pulse_time <= 1'b1;
            r_busy       <= 1'b1;
            r_pileup     <= 1'b0;
          end
        end
        RISE, FLAT, FALL: begin
          if (!bus.trapez_ena) begin
            r_state      <= IDLE;
            r_pulse_time <= 1'b0;
            r_busy       <= 1'b0;
            r_pileup     <= 1'b0;
          end else begin
            if (bus.trigger) r_pileup <= 1'b1;
            if (r_state == RISE) begin
              if (r_cnt == ONE) begin
                r_state <= FLAT;
                r_cnt   <= {1'b0, r_l} + ONE;
                r_peak  <= '0;
              end else begin
                r_cnt <= r_cnt - ONE;
              end
            end else if (r_state == FLAT) begin
              // Peak cleared on entry, so the first FLAT sample always loads.
              r_peak <= (bus.shaper_data > r_peak) ? bus.shaper_data : r_peak;
              if (r_cnt == ONE) begin
                r_state      <= FALL;
                r_cnt        <= {1'b0, r_k};
                r_end_impuls <= (r_k == CONST_W'(1));
              end else begin
                r_cnt <= r_cnt - ONE;
              end
            end else begin
              if (r_cnt == ONE) begin
                r_state         <= REPORT;
                r_pulse_time    <= 1'b0;
                r_energy_valid  <= 1'b1;
                r_energy_data   <= r_peak;
                r_energy_pileup <= r_pileup || bus.trigger;
              end else begin
                r_cnt        <= r_cnt - ONE;
                r_end_impuls <= (r_cnt == CW'(2));
              end
            end
          end
        end
        REPORT: begin
          if (bus.energy_ready) begin
            r_state         <= IDLE;
            r_busy          <= 1'b0;
            r_energy_valid  <= 1'b0;
            r_energy_pileup <= 1'b0;
            r_pileup        <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.pulse_time    = r_pulse_time;
  assign bus.k_trapez      = r_k;
  assign bus.l_trapez      = r_l;
  assign bus.M1_trapez     = r_m1;
  assign bus.M2_trapez     = r_m2;
  assign bus.energy_data   = r_energy_data;
  assign bus.energy_pileup = r_energy_pileup;
  assign bus.energy_valid  = r_energy_valid;
  assign bus.end_impuls    = r_end_impuls;
  assign bus.busy          = r_busy;
  assign bus.cfg_err       = r_cfg_err;
  assign bus.drop_cnt      = r_drop_cnt;
endmodule

// File: tb/tb_trapez_shaper_ctrl.sv
// Scoreboard bench for trapez_shaper_ctrl: expected energies queued while FLAT data is driven,
// popped on each valid/ready handshake; phase timing, config and counters checked inline.
module tb_trapez_shaper_ctrl;
  localparam int CONST_W = 10, DATA_W = 16, PIPE_LAT = 8, SHIFT_LEN = 60, DROP_W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  trapez_shaper_ctrl_if #(.CONST_W(CONST_W), .DATA_W(DATA_W), .DROP_W(DROP_W)) bus ();

  trapez_shaper_ctrl #(
    .CONST_W(CONST_W), .DATA_W(DATA_W), .PIPE_LAT(PIPE_LAT),
    .SHIFT_LEN(SHIFT_LEN), .DROP_W(DROP_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_drop = 0;
  logic [16:0] sb_q[$];
  logic [16:0] mon_e;
  bit          use_fix = 1'b0;
  logic [15:0] fix_dat[3] = '{16'd100, 16'd250, 16'd180};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && bus.energy_valid && bus.energy_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_result", sb_q.size(), 1);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_energy_data", bus.energy_data, mon_e[15:0]);
        chk("sb_energy_pileup", bus.energy_pileup, mon_e[16]);
      end
    end
  end

  task automatic cfg_write(input int k, input int l, input int m1, input int m2);
    bus.cfg_wr = 1'b1;
    bus.cfg_k  = CONST_W'(k);
    bus.cfg_l  = CONST_W'(l);
    bus.cfg_m1 = CONST_W'(m1);
    bus.cfg_m2 = CONST_W'(m2);
    tick();
    bus.cfg_wr = 1'b0;
  endtask

  // k/l are the constants the bench expects to time this pulse.
  task automatic do_pulse(input int k, input int l, input int pile_at, input int stall,
                          input bit cfg_same, input int cfg_at, input int ck, input int cl);
    int rise, n, hi_cnt, end_cnt, end_at;
    logic [15:0] peak, d;
    bit pile;
    rise = k + PIPE_LAT;
    n = rise + l + 1 + k;
    peak = '0; pile = 1'b0; hi_cnt = 0; end_cnt = 0; end_at = 0;
    bus.trigger = 1'b1;
    if (cfg_same) begin
      bus.cfg_wr = 1'b1;
      bus.cfg_k  = CONST_W'(k);
      bus.cfg_l  = CONST_W'(l);
    end
    tick();
    bus.trigger = 1'b0;
    bus.cfg_wr  = 1'b0;
    for (int c = 1; c <= n; c++) begin
      if (bus.pulse_time) hi_cnt++;
      if (bus.end_impuls) begin
        end_cnt++;
        end_at = c;
      end
      if (c == n) chk("k_active_in_pulse", bus.k_trapez, k);
      bus.trigger = (c == pile_at);
      if (c == pile_at) pile = 1'b1;
      if (c == cfg_at) begin
        bus.cfg_wr = 1'b1;
        bus.cfg_k  = CONST_W'(ck);
        bus.cfg_l  = CONST_W'(cl);
      end else begin
        bus.cfg_wr = 1'b0;
      end
      if (c > rise && c <= rise + l + 1) begin
        d = use_fix ? fix_dat[c - rise - 1] : 16'($urandom);
        bus.shaper_data = d;
        if (d > peak) peak = d;
      end
      if (c == rise + l + 1) sb_q.push_back({pile, peak});
      tick();
    end
    bus.trigger = 1'b0;
    bus.cfg_wr  = 1'b0;
    chk("pulse_len", hi_cnt, n);
    chk("end_impuls_count", end_cnt, 1);
    chk("end_impuls_cycle", end_at, n);
    chk("report_valid", bus.energy_valid, 1);
    chk("report_pulse_low", bus.pulse_time, 0);
    if (stall > 0) begin
      bus.energy_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        bus.trigger = (s == 0);
        if (s == 0) exp_drop++;
        chk("stall_data_stable", bus.energy_data, peak);
        chk("stall_valid", bus.energy_valid, 1);
        tick();
      end
      bus.trigger = 1'b0;
    end
    bus.energy_ready = 1'b1;
    tick();
    chk("idle_busy", bus.busy, 0);
    chk("idle_valid", bus.energy_valid, 0);
    chk("drop_cnt", bus.drop_cnt, exp_drop);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int vcnt;
    bus.trapez_ena   = 1'b1;
    bus.trigger      = 1'b0;
    bus.cfg_wr       = 1'b0;
    bus.cfg_k        = '0;
    bus.cfg_l        = '0;
    bus.cfg_m1       = '0;
    bus.cfg_m2       = '0;
    bus.shaper_data  = '0;
    bus.energy_ready = 1'b1;
    repeat (3) tick();
    chk("rst_pulse_time", bus.pulse_time, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.energy_valid, 0);
    chk("rst_k", bus.k_trapez, 4);
    chk("rst_l", bus.l_trapez, 2);
    chk("rst_m1", bus.M1_trapez, 0);
    chk("rst_m2", bus.M2_trapez, 0);
    chk("rst_drop", bus.drop_cnt, 0);
    chk("rst_cfg_err", bus.cfg_err, 0);
    reset = 1'b0;
    tick();

    // Fixed flat-top 100/250/180, ready high.
    use_fix = 1'b1;
    do_pulse(4, 2, 0, 0, 1'b0, 0, 0, 0);
    use_fix = 1'b0;
    // Pile-up trigger in RISE.
    do_pulse(4, 2, 8, 0, 1'b0, 0, 0, 0);
    // Stalled REPORT with a dropped trigger.
    do_pulse(4, 2, 0, 5, 1'b0, 0, 0, 0);

    // Enable removed in FLAT; pile-up from this aborted pulse must not leak.
    bus.trigger = 1'b1;
    tick();
    for (int c = 1; c <= 13; c++) begin
      bus.trigger = (c == 5);
      tick();
    end
    bus.trigger = 1'b0;
    chk("abort_pre_pulse", bus.pulse_time, 1);
    bus.trapez_ena = 1'b0;
    tick();
    chk("abort_pulse_low", bus.pulse_time, 0);
    chk("abort_busy", bus.busy, 0);
    bus.trigger = 1'b1;
    tick();
    bus.trigger = 1'b0;
    exp_drop++;
    chk("drop_disabled", bus.drop_cnt, exp_drop);
    vcnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.energy_valid) vcnt++;
      tick();
    end
    chk("abort_no_valid", vcnt, 0);
    bus.trapez_ena = 1'b1;

    // Config write in FLAT held until IDLE.
    do_pulse(4, 2, 0, 0, 1'b0, 14, 10, 5);
    chk("pend_applied_k", bus.k_trapez, 10);
    chk("pend_applied_l", bus.l_trapez, 5);
    do_pulse(10, 5, 0, 0, 1'b0, 0, 0, 0);

    cfg_write(0, 2, 0, 0);
    chk("err_k0", bus.cfg_err, 1);
    chk("err_k0_keep_k", bus.k_trapez, 10);
    tick();
    chk("err_clear", bus.cfg_err, 0);
    cfg_write(50, 10, 0, 0);
    chk("err_sum60", bus.cfg_err, 1);
    chk("err_sum60_keep_l", bus.l_trapez, 5);
    cfg_write(40, 19, 0, 0);
    chk("ok_sum59_err", bus.cfg_err, 0);
    chk("ok_sum59_k", bus.k_trapez, 40);
    chk("ok_sum59_l", bus.l_trapez, 19);
    cfg_write(3, 0, 7, 9);
    chk("cfg_m1", bus.M1_trapez, 7);
    chk("cfg_m2", bus.M2_trapez, 9);
    chk("cfg_k3", bus.k_trapez, 3);
    do_pulse(3, 0, 0, 0, 1'b0, 0, 0, 0);
    // Config and trigger together: pulse uses the new constants.
    do_pulse(5, 1, 0, 0, 1'b1, 0, 0, 0);

    // Reset in RISE with a pending config.
    bus.trigger = 1'b1;
    tick();
    bus.trigger = 1'b0;
    tick();
    tick();
    cfg_write(7, 1, 0, 0);
    chk("rise_busy", bus.busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_pulse", bus.pulse_time, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_drop", bus.drop_cnt, 0);
    chk("arst_k", bus.k_trapez, 4);
    chk("arst_m1", bus.M1_trapez, 0);
    exp_drop = 0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    tick();
    chk("pend_lost_k", bus.k_trapez, 4);
    chk("sb_leftover", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
